// File: rtl/ctrl_pipeline.sv
// Purpose : carries ID-stage control through ID/EX, EX/MEM, MEM/WB and resolves load-use, RAW, branch and jump hazards.
// Latency : bundle in ID at edge N shows on ex_* after N+1, mem_* after N+2, wb_* after N+3; hazard outputs are combinational.
// Backpr. : stall holds PC and IF/ID while ID/EX takes a bubble; a taken branch bubbles ID/EX and EX/MEM and wins over stall.
//
// Ports   : clock/reset_n (async active-low); id_* decoded control and rs/rt/rd from ID; ex_zero ALU flag of the EX instruction;
//           ex_reg_dst/ex_alu_src/ex_alu_op, mem_read/mem_write/mem_branch, wb_reg_write/wb_mem_to_reg/wb_wreg stage controls;
//           stall, flush_ifid, pc_src front-end controls; fwd_a/fwd_b operand select (00 regfile, 10 EX/MEM, 01 MEM/WB);
//           stall_cnt saturating count of stall cycles.
// Build   : define CTRL_PIPE_FWD_EN for forwarding (load-use stall only); otherwise RAW hazards stall and fwd_* stay 00.
module ctrl_pipeline #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             id_reg_dst,
    input  logic             id_jump,
    input  logic             id_branch,
    input  logic             id_mem_read,
    input  logic             id_mem_to_reg,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic [1:0]       id_alu_op,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             ex_zero,
    output logic             ex_reg_dst,
    output logic             ex_alu_src,
    output logic [1:0]       ex_alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_branch,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic [4:0]       wb_wreg,
    output logic             stall,
    output logic             flush_ifid,
    output logic             pc_src,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    // ID/EX state not exposed as ports
    logic       ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_reg_write;
    logic [4:0] ex_rt, ex_rd, ex_wreg;
    // EX/MEM state not exposed as ports
    logic       mem_reg_write, mem_mem_to_reg, mem_zero;
    logic [4:0] mem_wreg;

    // Sanitised capture values: fields that cannot matter are forced to 0
    logic       s_reg_dst, s_branch, s_mem_read, s_mem_to_reg, s_mem_write, s_alu_src, s_reg_write;
    logic [1:0] s_alu_op;
    logic [4:0] s_rs, s_rt, s_rd;

    always_comb begin
        s_reg_dst    = id_reg_dst & id_reg_write;
        s_mem_to_reg = id_mem_to_reg & id_reg_write;
        s_branch     = id_branch;
        s_mem_read   = id_mem_read;
        s_mem_write  = id_mem_write;
        s_alu_src    = id_alu_src;
        s_reg_write  = id_reg_write;
        s_alu_op     = id_alu_op;
        s_rs         = id_rs;
        s_rt         = id_rt;
        s_rd         = id_rd;
        // A jump is fully resolved in ID; nothing downstream may act on it
        if (id_jump) begin
            s_reg_dst    = 1'b0;
            s_mem_to_reg = 1'b0;
            s_branch     = 1'b0;
            s_mem_read   = 1'b0;
            s_mem_write  = 1'b0;
            s_alu_src    = 1'b0;
            s_reg_write  = 1'b0;
            s_alu_op     = 2'b00;
            s_rs         = 5'd0;
            s_rt         = 5'd0;
            s_rd         = 5'd0;
        end
    end

    assign ex_wreg = ex_reg_dst ? ex_rd : ex_rt;
    assign pc_src  = mem_branch & mem_zero;

    // $0 is excluded on the producer side, so it never matches anything
    logic hz_lu, hz_any;
    assign hz_lu = ex_mem_read & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

`ifdef CTRL_PIPE_FWD_EN
    logic [4:0] ex_rs;
    logic       fw_mem_a, fw_mem_b, fw_wb_a, fw_wb_b;

    assign fw_mem_a = mem_reg_write & (mem_wreg != 5'd0) & (mem_wreg == ex_rs);
    assign fw_mem_b = mem_reg_write & (mem_wreg != 5'd0) & (mem_wreg == ex_rt);
    assign fw_wb_a  = wb_reg_write  & (wb_wreg  != 5'd0) & (wb_wreg  == ex_rs);
    assign fw_wb_b  = wb_reg_write  & (wb_wreg  != 5'd0) & (wb_wreg  == ex_rt);
    // EX/MEM holds the younger result, so it wins over MEM/WB
    assign fwd_a    = fw_mem_a ? 2'b10 : (fw_wb_a ? 2'b01 : 2'b00);
    assign fwd_b    = fw_mem_b ? 2'b10 : (fw_wb_b ? 2'b01 : 2'b00);
    assign hz_any   = hz_lu;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)             ex_rs <= 5'd0;
        else if (pc_src || stall) ex_rs <= 5'd0;
        else                      ex_rs <= s_rs;
    end
`else
    logic raw_ex, raw_mem;

    // WB writes land in the regfile before the ID read, so only EX and MEM producers stall
    assign raw_ex  = ex_reg_write  & (ex_wreg  != 5'd0) & ((ex_wreg  == id_rs) | (ex_wreg  == id_rt));
    assign raw_mem = mem_reg_write & (mem_wreg != 5'd0) & ((mem_wreg == id_rs) | (mem_wreg == id_rt));
    assign fwd_a   = 2'b00;
    assign fwd_b   = 2'b00;
    assign hz_any  = hz_lu | raw_ex | raw_mem;
`endif

    // A taken branch squashes the stalled instruction anyway, so it overrides stall
    assign stall      = hz_any & ~pc_src;
    assign flush_ifid = pc_src | (id_jump & ~stall);

    // ID/EX
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n || 1'b0) begin
            {ex_reg_dst, ex_alu_src, ex_alu_op, ex_branch, ex_mem_read} <= '0;
            {ex_mem_to_reg, ex_mem_write, ex_reg_write, ex_rt, ex_rd}   <= '0;
        end else if (pc_src || stall) begin
            {ex_reg_dst, ex_alu_src, ex_alu_op, ex_branch, ex_mem_read} <= '0;
            {ex_mem_to_reg, ex_mem_write, ex_reg_write, ex_rt, ex_rd}   <= '0;
        end else begin
            ex_reg_dst    <= s_reg_dst;
            ex_alu_src    <= s_alu_src;
            ex_alu_op     <= s_alu_op;
            ex_branch     <= s_branch;
            ex_mem_read   <= s_mem_read;
            ex_mem_to_reg <= s_mem_to_reg;
            ex_mem_write  <= s_mem_write;
            ex_reg_write  <= s_reg_write;
            ex_rt         <= s_rt;
            ex_rd         <= s_rd;
        end
    end

    // EX/MEM: keeps advancing during a stall, bubbles on a taken branch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            {mem_read, mem_write, mem_branch, mem_reg_write, mem_mem_to_reg, mem_zero, mem_wreg} <= '0;
        end else if (pc_src) begin
            {mem_read, mem_write, mem_branch, mem_reg_write, mem_mem_to_reg, mem_zero, mem_wreg} <= '0;
        end else begin
            mem_read       <= ex_mem_read;
            mem_write      <= ex_mem_write;
            mem_branch     <= ex_branch;
            mem_reg_write  <= ex_reg_write;
            mem_mem_to_reg <= ex_mem_to_reg;
            mem_zero       <= ex_zero;
            mem_wreg       <= ex_wreg;
        end
    end

    // MEM/WB: the branch itself is already past EX/MEM, so this stage always captures
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            {wb_reg_write, wb_mem_to_reg, wb_wreg} <= '0;
        end else begin
            wb_reg_write  <= mem_reg_write;
            wb_mem_to_reg <= mem_mem_to_reg;
            wb_wreg       <= mem_wreg;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                        stall_cnt <= '0;
        else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule
